// File: rtl/rd_resume_pkg.sv
// Shared types and constants for the read-transfer resume controller.
package rd_resume_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int LEN_WIDTH_DEF  = 13;
    localparam int SPLIT_CNT_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACTIVE = 3'd1,
        ST_CALC   = 3'd2,
        ST_REQ    = 3'd3,
        ST_DONE   = 3'd4
    } rd_state_e;

    // Saturating increment for the split statistics counter.
    function automatic logic [SPLIT_CNT_W-1:0] sat_inc(input logic [SPLIT_CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/rd_xfer_resume_ctrl_sync_2ff.sv
// Two-flop synchroniser bringing the page-boundary level into the mem_clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rd_xfer_resume_ctrl.sv
// Read transfer controller that re-issues a continuation read after a page-boundary split.
// Optional split statistics counter enabled by macro RD_RESUME_STAT_EN.
module rd_xfer_resume_ctrl
    import rd_resume_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LEN_WIDTH      = LEN_WIDTH_DEF
) (
    input  logic                      mem_clk,
    input  logic                      rst_n,
    input  logic                      xfer_start,
    input  logic [AXI_ADDR_WIDTH-1:0] xfer_addr,
    input  logic [LEN_WIDTH-1:0]      xfer_len,
    input  logic                      rd_pg_bndry_expired,
    input  logic [AXI_ADDR_WIDTH-1:0] rd_last_addr,
    input  logic                      rd_done,
    input  logic                      abort,
    output logic                      resume_req,
    input  logic                      resume_ack,
    output logic [AXI_ADDR_WIDTH-1:0] resume_addr,
    output logic [LEN_WIDTH-1:0]      resume_len,
    output logic                      busy,
    output logic                      xfer_done,
    output logic                      len_err,
    output logic [SPLIT_CNT_W-1:0]    split_cnt,
    output rd_state_e                 state_dbg
);

    // Handshake: resume_req rises with resume_addr/resume_len valid and holds all three
    // stable until resume_ack is seen high on a mem_clk edge while in REQ.

    rd_state_e                 state;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr;
    logic [AXI_ADDR_WIDTH-1:0] nxt_addr;
    logic [LEN_WIDTH-1:0]      rem_len;
    logic [LEN_WIDTH-1:0]      consumed;
    logic                      exp_s;
    logic                      exp_s_d;
    logic                      exp_rise;

    sync_2ff u_sync_exp (
        .clk   (mem_clk),
        .rst_n (rst_n),
        .d     (rd_pg_bndry_expired),
        .q     (exp_s)
    );

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_s_d <= 1'b0;
        end else begin
            exp_s_d <= exp_s;
        end
    end

    // Only a fresh low-to-high edge counts; a level held across an ack is one split.
    assign exp_rise  = exp_s & ~exp_s_d;
    assign state_dbg = state;

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cur_addr    <= '0;
            nxt_addr    <= '0;
            rem_len     <= '0;
            consumed    <= '0;
            resume_req  <= 1'b0;
            resume_addr <= '0;
            resume_len  <= '0;
            busy        <= 1'b0;
            xfer_done   <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            xfer_done <= 1'b0;
            len_err   <= 1'b0;
            if (abort) begin
                state      <= ST_IDLE;
                resume_req <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (xfer_start) begin
                            cur_addr <= xfer_addr;
                            rem_len  <= xfer_len;
                            busy     <= 1'b1;
                            state    <= ST_ACTIVE;
                        end
                    end
                    ST_ACTIVE: begin
                        if (rd_done) begin
                            xfer_done <= 1'b1;
                            state     <= ST_DONE;
                        end else if (exp_rise) begin
                            nxt_addr <= rd_last_addr;
                            consumed <= LEN_WIDTH'(rd_last_addr - cur_addr);
                            state    <= ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        if (consumed >= rem_len) begin
                            rem_len   <= '0;
                            len_err   <= (consumed > rem_len);
                            xfer_done <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            rem_len     <= rem_len - consumed;
                            cur_addr    <= nxt_addr;
                            resume_addr <= nxt_addr;
                            resume_len  <= rem_len - consumed;
                            resume_req  <= 1'b1;
                            state       <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (resume_ack) begin
                            resume_req <= 1'b0;
                            state      <= ST_ACTIVE;
                        end
                    end
                    ST_DONE: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        resume_req <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef RD_RESUME_STAT_EN
    logic split_inc;
    logic split_clr;

    assign split_inc = (state == ST_CALC) && !abort && (consumed < rem_len);
    assign split_clr = (state == ST_IDLE) && !abort && xfer_start;

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            split_cnt <= '0;
        end else if (split_clr) begin
            split_cnt <= '0;
        end else if (split_inc) begin
            split_cnt <= sat_inc(split_cnt);
        end
    end
`else
    assign split_cnt = '0;
`endif

endmodule

// File: tb/tb_rd_xfer_resume_ctrl.sv
// Directed table-driven bench for rd_xfer_resume_ctrl; split_cnt expectations follow RD_RESUME_STAT_EN.
module tb_rd_xfer_resume_ctrl;
    import rd_resume_pkg::*;

    logic        mem_clk;
    logic        rst_n;
    logic        xfer_start;
    logic [31:0] xfer_addr;
    logic [12:0] xfer_len;
    logic        rd_pg_bndry_expired;
    logic [31:0] rd_last_addr;
    logic        rd_done;
    logic        abort;
    logic        resume_req;
    logic        resume_ack;
    logic [31:0] resume_addr;
    logic [12:0] resume_len;
    logic        busy;
    logic        xfer_done;
    logic        len_err;
    logic [7:0]  split_cnt;
    rd_state_e   state_dbg;

    int total = 0;
    int bad   = 0;
    int req_rises  = 0;
    int done_rises = 0;
    logic req_prev  = 1'b0;
    logic done_prev = 1'b0;

    rd_xfer_resume_ctrl dut (
        .mem_clk             (mem_clk),
        .rst_n               (rst_n),
        .xfer_start          (xfer_start),
        .xfer_addr           (xfer_addr),
        .xfer_len            (xfer_len),
        .rd_pg_bndry_expired (rd_pg_bndry_expired),
        .rd_last_addr        (rd_last_addr),
        .rd_done             (rd_done),
        .abort               (abort),
        .resume_req          (resume_req),
        .resume_ack          (resume_ack),
        .resume_addr         (resume_addr),
        .resume_len          (resume_len),
        .busy                (busy),
        .xfer_done           (xfer_done),
        .len_err             (len_err),
        .split_cnt           (split_cnt),
        .state_dbg           (state_dbg)
    );

    // Clock / reset
    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Edge counters for request and done pulses, sampled mid-cycle
    always @(negedge mem_clk) begin
        if (resume_req && !req_prev) req_rises++;
        if (xfer_done && !done_prev) done_rises++;
        req_prev  = resume_req;
        done_prev = xfer_done;
    end

    // Scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Drivers
    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic idle_inputs();
        xfer_start          = 1'b0;
        rd_pg_bndry_expired = 1'b0;
        rd_done             = 1'b0;
        resume_ack          = 1'b0;
        abort               = 1'b0;
    endtask

    task automatic start_xfer(input logic [31:0] addr, input logic [12:0] len);
        xfer_addr  = addr;
        xfer_len   = len;
        xfer_start = 1'b1;
        tick();
        xfer_start = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    typedef struct {
        logic        start;
        logic [31:0] addr;
        logic [12:0] len;
        logic        exp;
        logic [31:0] last;
        logic        done_in;
        logic        ack;
        logic        exp_req;
        logic        exp_busy;
        logic        exp_done;
        logic        chk_pay;
        logic [31:0] exp_addr;
        logic [12:0] exp_len;
        rd_state_e   exp_state;
    } vec_t;

    vec_t vecs[10];

    int base_req;
    int base_done;
    logic [7:0] exp_split;

    initial begin
        // Single split, start 0x0F0 len 64, split at 0x100 -> resume 0x100 / 48
        vecs[0] = '{1'b1, 32'h0F0, 13'd64, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   13'd0,  ST_ACTIVE};
        vecs[1] = '{1'b0, 32'h0,   13'd0,  1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   13'd0,  ST_ACTIVE};
        vecs[2] = '{1'b0, 32'h0,   13'd0,  1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   13'd0,  ST_ACTIVE};
        vecs[3] = '{1'b0, 32'h0,   13'd0,  1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   13'd0,  ST_CALC};
        vecs[4] = '{1'b0, 32'h0,   13'd0,  1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 13'd48, ST_REQ};
        vecs[5] = '{1'b0, 32'h0,   13'd0,  1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   13'd0,  ST_ACTIVE};
        vecs[6] = '{1'b0, 32'h0,   13'd0,  1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   13'd0,  ST_ACTIVE};
        vecs[7] = '{1'b0, 32'h0,   13'd0,  1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   13'd0,  ST_DONE};
        vecs[8] = '{1'b0, 32'h0,   13'd0,  1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   13'd0,  ST_IDLE};
        vecs[9] = '{1'b0, 32'h0,   13'd0,  1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   13'd0,  ST_IDLE};

        idle_inputs();
        xfer_addr    = '0;
        xfer_len     = '0;
        rd_last_addr = '0;
        rst_n        = 1'b0;
        ticks(2);
        check("reset_req",   32'(resume_req), 0);
        check("reset_busy",  32'(busy), 0);
        check("reset_done",  32'(xfer_done), 0);
        check("reset_lenerr", 32'(len_err), 0);
        check("reset_addr",  resume_addr, 0);
        check("reset_len",   32'(resume_len), 0);
        check("reset_split", 32'(split_cnt), 0);
        check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
        rst_n = 1'b1;
        ticks(2);

        // Table: single split with ack, then completion
        base_req = req_rises;
        for (int i = 0; i < 10; i++) begin
            xfer_start          = vecs[i].start;
            xfer_addr           = vecs[i].addr;
            xfer_len            = vecs[i].len;
            rd_pg_bndry_expired = vecs[i].exp;
            rd_last_addr        = vecs[i].last;
            rd_done             = vecs[i].done_in;
            resume_ack          = vecs[i].ack;
            tick();
            check($sformatf("vec%0d_req", i),   32'(resume_req), 32'(vecs[i].exp_req));
            check($sformatf("vec%0d_busy", i),  32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_done", i),  32'(xfer_done), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d_lenerr", i), 32'(len_err), 0);
            check($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(vecs[i].exp_state));
            if (vecs[i].chk_pay) begin
                check($sformatf("vec%0d_raddr", i), resume_addr, vecs[i].exp_addr);
                check($sformatf("vec%0d_rlen", i),  32'(resume_len), 32'(vecs[i].exp_len));
            end
        end
        idle_inputs();
        check("tbl_req_count", 32'(req_rises - base_req), 1);

        // No split: rd_done -> xfer_done on the next edge, never a request
        base_req = req_rises;
        start_xfer(32'h0F0, 13'd64);
        ticks(3);
        resume_ack = 1'b1;
        tick();
        resume_ack = 1'b0;
        check("nosplit_ack_ignored", 32'(state_dbg), 32'(ST_ACTIVE));
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("nosplit_done", 32'(xfer_done), 1);
        tick();
        check("nosplit_done_1cyc", 32'(xfer_done), 0);
        check("nosplit_idle", 32'(busy), 0);
        check("nosplit_no_req", 32'(req_rises - base_req), 0);

        // Held level across ack is one split; a second rise is a second split
        base_req = req_rises;
        start_xfer(32'h0F0, 13'd1024);
        rd_last_addr        = 32'h100;
        rd_pg_bndry_expired = 1'b1;
        ticks(4);
        check("held_req1", 32'(resume_req), 1);
        check("held_addr1", resume_addr, 32'h100);
        check("held_len1", 32'(resume_len), 1008);
        resume_ack = 1'b1;
        tick();
        resume_ack = 1'b0;
        ticks(15);
        check("held_one_req", 32'(req_rises - base_req), 1);
        rd_pg_bndry_expired = 1'b0;
        ticks(3);
        rd_last_addr        = 32'h200;
        rd_pg_bndry_expired = 1'b1;
        ticks(4);
        check("held_req2", 32'(resume_req), 1);
        check("held_addr2", resume_addr, 32'h200);
        check("held_len2", 32'(resume_len), 752);
        resume_ack = 1'b1;
        tick();
        resume_ack          = 1'b0;
        rd_pg_bndry_expired = 1'b0;
        rd_done             = 1'b1;
        tick();
        rd_done = 1'b0;
        check("held_done", 32'(xfer_done), 1);
        check("held_two_req", 32'(req_rises - base_req), 2);
`ifdef RD_RESUME_STAT_EN
        exp_split = 8'd2;
`else
        exp_split = 8'd0;
`endif
        check("held_split_cnt", 32'(split_cnt), 32'(exp_split));
        ticks(2);

        // Over-consumption: len 16, split at start+32 -> len_err with done, no request
        base_req = req_rises;
        start_xfer(32'h0F0, 13'd16);
        check("lenerr_split_clr", 32'(split_cnt), 0);
        rd_last_addr        = 32'h110;
        rd_pg_bndry_expired = 1'b1;
        ticks(3);
        check("lenerr_pre", 32'(len_err), 0);
        tick();
        check("lenerr_pulse", 32'(len_err), 1);
        check("lenerr_done", 32'(xfer_done), 1);
        tick();
        rd_pg_bndry_expired = 1'b0;
        check("lenerr_1cyc", 32'(len_err), 0);
        check("lenerr_no_req", 32'(req_rises - base_req), 0);
        ticks(3);

        // rd_done and exp_rise coincide: rd_done wins
        base_req = req_rises;
        start_xfer(32'h0F0, 13'd64);
        rd_last_addr        = 32'h100;
        rd_pg_bndry_expired = 1'b1;
        ticks(2);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("prio_done", 32'(xfer_done), 1);
        check("prio_state", 32'(state_dbg), 32'(ST_DONE));
        ticks(5);
        rd_pg_bndry_expired = 1'b0;
        check("prio_no_req", 32'(req_rises - base_req), 0);
        ticks(3);

        // Abort while requesting
        base_done = done_rises;
        start_xfer(32'h0F0, 13'd64);
        rd_last_addr        = 32'h100;
        rd_pg_bndry_expired = 1'b1;
        ticks(4);
        check("abort_req_up", 32'(resume_req), 1);
        abort = 1'b1;
        tick();
        abort               = 1'b0;
        rd_pg_bndry_expired = 1'b0;
        check("abort_req_drop", 32'(resume_req), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
        ticks(5);
        check("abort_no_done", 32'(done_rises - base_done), 0);

        // Reset pulsed in CALC
        base_req  = req_rises;
        base_done = done_rises;
        start_xfer(32'h0F0, 13'd64);
        rd_last_addr        = 32'h100;
        rd_pg_bndry_expired = 1'b1;
        ticks(3);
        check("rst_in_calc", 32'(state_dbg), 32'(ST_CALC));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_busy", 32'(busy), 0);
        check("rst_async_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rst_async_outs", {resume_req, xfer_done, len_err, split_cnt}, 0);
        tick();
        rst_n = 1'b1;
        ticks(8);
        rd_pg_bndry_expired = 1'b0;
        check("rst_no_req", 32'(req_rises - base_req), 0);
        check("rst_no_done", 32'(done_rises - base_done), 0);
        check("rst_idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
